// File: rtl/pcs_sync_param.sv
// pcs_sync_param -- 1000BASE-X PCS receive code-group synchronization.
// Acquires code-group alignment from comma/IDLE pairs, tracks parity
// through rx_even and drops sync after BAD_LIMIT net bad code-groups,
// with GOOD_LIMIT consecutive good code-groups cancelling one bad.
// Optional build macro PCS_SYNC_STATS_EN adds sync_loss_cnt, a saturating
// count of SYNC_ACQUIRED -> LOSS_OF_SYNC transitions.
// PUDI/SUDI bit order is {a,b,c,d,e,i,f,g,h,j}, so K28.5 is 10'h0FA / 10'h305.
module pcs_sync_param #(
  parameter int COMMA_ACQ  = 3,
  parameter int BAD_LIMIT  = 4,
  parameter int GOOD_LIMIT = 4
) (
  input  logic       clk,
  input  logic       mr_main_reset,
  input  logic       signal_detect,
  input  logic       mr_loopback,
  input  logic [9:0] PUDI,
  output logic [9:0] SUDI,
  output logic       rx_even,
  output logic       code_sync_status,
  output logic [2:0] sync_bad_cnt
`ifdef PCS_SYNC_STATS_EN
  ,
  output logic [7:0] sync_loss_cnt
`endif
);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    COMMA_DETECT  = 2'd1,
    ACQUIRE_SYNC  = 2'd2,
    SYNC_ACQUIRED = 2'd3
  } state_t;

  localparam logic [2:0] ACQ_L  = 3'(COMMA_ACQ);
  localparam logic [2:0] BAD_L  = 3'(BAD_LIMIT);
  localparam logic [2:0] GOOD_L = 3'(GOOD_LIMIT);

  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] D162_N = 10'b0110110101;
  localparam logic [9:0] D162_P = 10'b1001000101;
  localparam logic [9:0] D56    = 10'b1010010110;

  // 5b/6b sub-block in its RD- form (abcdei).
  function automatic logic [5:0] tab6(input logic [4:0] x);
    logic [5:0] s;
    case (x)
      5'd0:  s = 6'b100111;
      5'd1:  s = 6'b011101;
      5'd2:  s = 6'b101101;
      5'd3:  s = 6'b110001;
      5'd4:  s = 6'b110101;
      5'd5:  s = 6'b101001;
      5'd6:  s = 6'b011001;
      5'd7:  s = 6'b111000;
      5'd8:  s = 6'b111001;
      5'd9:  s = 6'b100101;
      5'd10: s = 6'b010101;
      5'd11: s = 6'b110100;
      5'd12: s = 6'b001101;
      5'd13: s = 6'b101100;
      5'd14: s = 6'b011100;
      5'd15: s = 6'b010111;
      5'd16: s = 6'b011011;
      5'd17: s = 6'b100011;
      5'd18: s = 6'b010011;
      5'd19: s = 6'b110010;
      5'd20: s = 6'b001011;
      5'd21: s = 6'b101010;
      5'd22: s = 6'b011010;
      5'd23: s = 6'b111010;
      5'd24: s = 6'b110011;
      5'd25: s = 6'b100110;
      5'd26: s = 6'b010110;
      5'd27: s = 6'b110110;
      5'd28: s = 6'b001110;
      5'd29: s = 6'b101110;
      5'd30: s = 6'b011110;
      default: s = 6'b101011;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Full 8b/10b encode of one byte in the given starting running disparity.
  function automatic logic [9:0] enc10(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       rdm;
    logic       a7;
    x  = b[4:0];
    y  = b[7:5];
    s6 = (k && x == 5'd28) ? 6'b001111 : tab6(x);
    if (rd && (ones6(s6) != 3'd3 || x == 5'd7)) s6 = ~s6;
    rdm = rd ^ (ones6(s6) != 3'd3);
    a7  = (!rdm && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
          (rdm && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    if (k && x == 5'd28) begin
      case (y)
        3'd0: s4 = 4'b0100;
        3'd1: s4 = 4'b1001;
        3'd2: s4 = 4'b0101;
        3'd3: s4 = 4'b0011;
        3'd4: s4 = 4'b0010;
        3'd5: s4 = 4'b1010;
        3'd6: s4 = 4'b0110;
        default: s4 = 4'b1000;
      endcase
      if (!rdm) s4 = ~s4;
    end else begin
      case (y)
        3'd0: s4 = 4'b1011;
        3'd1: s4 = 4'b1001;
        3'd2: s4 = 4'b0101;
        3'd3: s4 = 4'b1100;
        3'd4: s4 = 4'b1101;
        3'd5: s4 = 4'b1010;
        3'd6: s4 = 4'b0110;
        default: s4 = (a7 || k) ? 4'b0111 : 4'b1110;
      endcase
      if (rdm && (y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7)) s4 = ~s4;
    end
    return {s6, s4};
  endfunction

  function automatic logic is_kcode(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           (b[7:5] == 3'd7 && (b[4:0] == 5'd23 || b[4:0] == 5'd27 ||
                               b[4:0] == 5'd29 || b[4:0] == 5'd30));
  endfunction

  // A code-group is valid if it appears in either disparity column of the tables.
  function automatic logic is_valid(input logic [9:0] cg);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 512; i++) begin
      if (enc10(8'(i), 1'b0, i[8]) == cg) v = 1'b1;
      if (is_kcode(8'(i)) && enc10(8'(i), 1'b1, i[8]) == cg) v = 1'b1;
    end
    return v;
  endfunction

  state_t     state, state_nxt;
  logic [2:0] acq_cnt, acq_nxt;
  logic [2:0] bad_cnt, bad_nxt;
  logic [2:0] good_cnt, good_nxt;
  logic       rx_even_nxt;
  logic       sig_ok;
  logic       cg_comma;
  logic       cg_idle;
  logic       cg_valid;
  logic       cg_bad;

  assign sig_ok   = signal_detect | mr_loopback;
  assign cg_comma = (PUDI == K285_N) || (PUDI == K285_P);
  assign cg_idle  = (PUDI == D162_N) || (PUDI == D162_P) || (PUDI == D56);
  assign cg_valid = is_valid(PUDI);
  assign cg_bad   = !cg_valid || (cg_comma && rx_even);

  // Next-state and counter updates of the synchronization FSM.
  always_comb begin
    state_nxt = state;
    acq_nxt   = acq_cnt;
    bad_nxt   = bad_cnt;
    good_nxt  = good_cnt;
    if (!sig_ok) begin
      state_nxt = LOSS_OF_SYNC;
      acq_nxt   = 3'd0;
      bad_nxt   = 3'd0;
      good_nxt  = 3'd0;
    end else begin
      case (state)
        LOSS_OF_SYNC: begin
          if (cg_comma) state_nxt = COMMA_DETECT;
          else          acq_nxt   = 3'd0;
        end
        COMMA_DETECT: begin
          if (cg_idle) begin
            if (acq_cnt + 3'd1 == ACQ_L) begin
              state_nxt = SYNC_ACQUIRED;
              bad_nxt   = 3'd0;
              good_nxt  = 3'd0;
            end else begin
              state_nxt = ACQUIRE_SYNC;
              acq_nxt   = acq_cnt + 3'd1;
            end
          end else begin
            state_nxt = LOSS_OF_SYNC;
            acq_nxt   = 3'd0;
          end
        end
        ACQUIRE_SYNC: begin
          if (cg_comma && !rx_even) begin
            state_nxt = COMMA_DETECT;
          end else if (cg_bad) begin
            state_nxt = LOSS_OF_SYNC;
            acq_nxt   = 3'd0;
          end
        end
        SYNC_ACQUIRED: begin
          if (cg_bad) begin
            if (bad_cnt + 3'd1 == BAD_L) begin
              state_nxt = LOSS_OF_SYNC;
              acq_nxt   = 3'd0;
              bad_nxt   = 3'd0;
              good_nxt  = 3'd0;
            end else begin
              bad_nxt  = bad_cnt + 3'd1;
              good_nxt = 3'd0;
            end
          end else if (bad_cnt != 3'd0) begin
            if (good_cnt + 3'd1 == GOOD_L) begin
              bad_nxt  = bad_cnt - 3'd1;
              good_nxt = 3'd0;
            end else begin
              good_nxt = good_cnt + 3'd1;
            end
          end else begin
            good_nxt = 3'd0;
          end
        end
        default: begin
          state_nxt = LOSS_OF_SYNC;
          acq_nxt   = 3'd0;
          bad_nxt   = 3'd0;
          good_nxt  = 3'd0;
        end
      endcase
    end
    // Entering COMMA_DETECT re-aligns parity so the comma sits on an even slot.
    rx_even_nxt = (state_nxt == COMMA_DETECT) ? 1'b1 : ~rx_even;
  end

  // FSM state, counters, parity and status registers.
  always_ff @(posedge clk) begin
    if (mr_main_reset) begin
      state            <= LOSS_OF_SYNC;
      acq_cnt          <= 3'd0;
      bad_cnt          <= 3'd0;
      good_cnt         <= 3'd0;
      rx_even          <= 1'b0;
      code_sync_status <= 1'b0;
    end else begin
      state            <= state_nxt;
      acq_cnt          <= acq_nxt;
      bad_cnt          <= bad_nxt;
      good_cnt         <= good_nxt;
      rx_even          <= rx_even_nxt;
      code_sync_status <= (state_nxt == SYNC_ACQUIRED);
    end
  end

  // One-cycle code-group delay towards the receiver.
  always_ff @(posedge clk) begin
    if (mr_main_reset) SUDI <= 10'd0;
    else               SUDI <= PUDI;
  end

  assign sync_bad_cnt = bad_cnt;

`ifdef PCS_SYNC_STATS_EN
  // Saturating count of sync losses from any cause other than reset.
  always_ff @(posedge clk) begin
    if (mr_main_reset) begin
      sync_loss_cnt <= 8'd0;
    end else if (state == SYNC_ACQUIRED && state_nxt == LOSS_OF_SYNC &&
                 sync_loss_cnt != 8'hFF) begin
      sync_loss_cnt <= sync_loss_cnt + 8'd1;
    end
  end
`endif

endmodule
